// File: rtl/debouncer_nch.sv
// Multi-channel button debouncer: per channel a 2-flop synchronizer, a stability
// counter and a RELEASED/PRESSED/LONG state machine producing press/release/long events.
module debouncer_nch #(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 30,
  parameter int LONG_CNT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn_raw,
  input  logic [N_CH-1:0]   ch_en,
  output logic [N_CH-1:0]   btn_level,
  output logic [N_CH-1:0]   press_pulse,
  output logic [N_CH-1:0]   release_pulse,
  output logic [N_CH-1:0]   long_pulse,
  output logic [N_CH-1:0]   long_held,
  output logic [2*N_CH-1:0] dbg_state
);

  localparam int SW = $clog2(STABLE_CNT);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } state_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [SW-1:0]   r_stab [N_CH];
  logic [HW-1:0]   r_hold [N_CH];
  state_t          r_state [N_CH];

  logic [N_CH-1:0] w_diff;
  logic [N_CH-1:0] w_accept;

  // Synchronizer keeps running while a channel is disabled so re-enable sees the live level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_diff   = '0;
    w_accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_diff[i]   = r_sync2[i] ^ btn_level[i];
      w_accept[i] = w_diff[i] && (r_stab[i] == STAB_LAST);
    end
  end

  // Level is 0 exactly in RELEASED, so an accepted change there is a rise and elsewhere a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_RELEASED;
        r_stab[i]  <= '0;
        r_hold[i]  <= '0;
      end
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      long_held     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        long_pulse[i]    <= 1'b0;
        if (!ch_en[i]) begin
          r_state[i]   <= ST_RELEASED;
          r_stab[i]    <= '0;
          r_hold[i]    <= '0;
          btn_level[i] <= 1'b0;
          long_held[i] <= 1'b0;
        end else begin
          if (!w_diff[i] || w_accept[i]) begin
            r_stab[i] <= '0;
          end else begin
            r_stab[i] <= r_stab[i] + SW'(1);
          end
          if (w_accept[i]) begin
            btn_level[i] <= ~btn_level[i];
          end
          case (r_state[i])
            ST_RELEASED: begin
              if (w_accept[i]) begin
                r_state[i]     <= ST_PRESSED;
                press_pulse[i] <= 1'b1;
                r_hold[i]      <= '0;
              end
            end
            ST_PRESSED: begin
              if (w_accept[i]) begin
                r_state[i]       <= ST_RELEASED;
                release_pulse[i] <= 1'b1;
                r_hold[i]        <= '0;
              end else if (r_hold[i] == HOLD_LAST) begin
                r_state[i]    <= ST_LONG;
                long_pulse[i] <= 1'b1;
                long_held[i]  <= 1'b1;
                r_hold[i]     <= r_hold[i] + HW'(1);
              end else begin
                r_hold[i] <= r_hold[i] + HW'(1);
              end
            end
            ST_LONG: begin
              if (w_accept[i]) begin
                r_state[i]       <= ST_RELEASED;
                release_pulse[i] <= 1'b1;
                long_held[i]     <= 1'b0;
                r_hold[i]        <= '0;
              end
            end
            default: begin
              r_state[i]   <= ST_RELEASED;
              btn_level[i] <= 1'b0;
              long_held[i] <= 1'b0;
              r_hold[i]    <= '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < N_CH; i++) begin
      dbg_state[2*i +: 2] = r_state[i];
    end
  end

endmodule

// File: tb/tb_debouncer_nch.sv
// Bench for debouncer_nch: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against a time-stamp based behavioural model.
module tb_debouncer_nch;

  localparam int N_CH       = 4;
  localparam int STABLE_CNT = 4;
  localparam int LONG_CNT   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   btn_raw;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH-1:0]   btn_level;
  logic [N_CH-1:0]   press_pulse;
  logic [N_CH-1:0]   release_pulse;
  logic [N_CH-1:0]   long_pulse;
  logic [N_CH-1:0]   long_held;
  logic [2*N_CH-1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  debouncer_nch #(
    .N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .LONG_CNT(LONG_CNT)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .ch_en(ch_en),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .long_held(long_held), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Behavioural model: raw delayed two edges, level accepted after STABLE_CNT
  // consecutive disagreeing cycles, long event LONG_CNT edges after the press edge.
  logic [N_CH-1:0] sync_q[$];
  logic [N_CH-1:0] m_level, m_press, m_rel, m_long, m_held;
  int              m_run [N_CH];
  int              m_press_cyc [N_CH];
  int              cyc = 0;
  bit              started = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      if (rst) begin
        sync_q.delete();
        sync_q.push_back('0);
        sync_q.push_back('0);
        m_level = '0;
        m_held  = '0;
        for (int i = 0; i < N_CH; i++) begin
          m_run[i]       = 0;
          m_press_cyc[i] = -1;
        end
      end else begin
        logic [N_CH-1:0] sync_now;
        sync_now = sync_q.pop_front();
        sync_q.push_back(btn_raw);
        for (int i = 0; i < N_CH; i++) begin
          if (!ch_en[i]) begin
            m_level[i]     = 1'b0;
            m_held[i]      = 1'b0;
            m_run[i]       = 0;
            m_press_cyc[i] = -1;
          end else begin
            bit fell;
            fell = 1'b0;
            if (sync_now[i] != m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == STABLE_CNT) begin
              m_run[i]   = 0;
              m_level[i] = ~m_level[i];
              if (m_level[i]) begin
                m_press[i]     = 1'b1;
                m_press_cyc[i] = cyc;
              end else begin
                m_rel[i]       = 1'b1;
                m_held[i]      = 1'b0;
                m_press_cyc[i] = -1;
                fell           = 1'b1;
              end
            end
            if (!fell && m_level[i] && !m_held[i] && (cyc - m_press_cyc[i] == LONG_CNT)) begin
              m_long[i] = 1'b1;
              m_held[i] = 1'b1;
            end
          end
        end
      end
      started = 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard compare: every cycle on the falling edge
  initial begin
    wait (started);
    forever begin
      logic [2*N_CH-1:0] exp_dbg;
      @(negedge clk);
      exp_dbg = '0;
      for (int i = 0; i < N_CH; i++)
        exp_dbg[2*i +: 2] = m_held[i] ? 2'd2 : (m_level[i] ? 2'd1 : 2'd0);
      cmp("btn_level", 32'(btn_level), 32'(m_level));
      cmp("press_pulse", 32'(press_pulse), 32'(m_press));
      cmp("release_pulse", 32'(release_pulse), 32'(m_rel));
      cmp("long_pulse", 32'(long_pulse), 32'(m_long));
      cmp("long_held", 32'(long_held), 32'(m_held));
      cmp("dbg_state", 32'(dbg_state), 32'(exp_dbg));
    end
  end

  // Driver tasks: advance n rising edges, land 1 time unit after the last one
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hold_left [N_CH];
    rst     = 1'b1;
    btn_raw = '0;
    ch_en   = '1;
    edges(2);
    cmp("reset_level", 32'(btn_level), 32'h0);
    cmp("reset_dbg", 32'(dbg_state), 32'h0);
    rst = 1'b0;

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    edges(1);
    cmp("post_reset_outputs", 32'({btn_level, press_pulse, release_pulse, long_pulse, long_held}), 32'h0);
    edges(4);
    cmp("t1_level_edge5", 32'(btn_level), 32'h0);
    edges(1);
    cmp("t1_level_edge6", 32'(btn_level), 32'h1);
    cmp("t1_press_edge6", 32'(press_pulse), 32'h1);
    edges(1);
    cmp("t1_press_edge7", 32'(press_pulse), 32'h0);
    btn_raw[0] = 1'b0;
    edges(6);
    cmp("t1_release", 32'(release_pulse), 32'h1);
    edges(2);

    // Bounce on channel 1 then steady
    foreach (hold_left[i]) hold_left[i] = 0;
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      edges(1);
      cmp("t2_bounce_level", 32'(btn_level), 32'h0);
      cmp("t2_bounce_press", 32'(press_pulse), 32'h0);
    end
    btn_raw[1] = 1'b1;
    edges(5);
    cmp("t2_no_early_press", 32'(press_pulse), 32'h0);
    edges(1);
    cmp("t2_press", 32'(press_pulse), 32'h2);
    btn_raw[1] = 1'b0;
    edges(8);

    // Long press on channel 2
    btn_raw[2] = 1'b1;
    edges(6);
    cmp("t3_press", 32'(press_pulse), 32'h4);
    edges(9);
    cmp("t3_long_early", 32'(long_pulse), 32'h0);
    edges(1);
    cmp("t3_long_pulse", 32'(long_pulse), 32'h4);
    cmp("t3_long_held", 32'(long_held), 32'h4);
    edges(5);
    cmp("t3_long_once", 32'(long_pulse), 32'h0);
    cmp("t3_held_kept", 32'(long_held), 32'h4);
    btn_raw[2] = 1'b0;
    edges(6);
    cmp("t3_release", 32'(release_pulse), 32'h4);
    cmp("t3_held_clear", 32'(long_held), 32'h0);
    edges(2);

    // Fall accepted on the same edge the long event would fire
    btn_raw[2] = 1'b1;
    edges(6);
    cmp("t3b_press", 32'(press_pulse), 32'h4);
    edges(4);
    btn_raw[2] = 1'b0;
    edges(6);
    cmp("t3b_release", 32'(release_pulse), 32'h4);
    cmp("t3b_no_long", 32'(long_pulse), 32'h0);
    cmp("t3b_no_held", 32'(long_held), 32'h0);
    edges(2);

    // Simultaneous channels 0 and 3
    btn_raw = 4'b1001;
    edges(6);
    cmp("t4_press", 32'(press_pulse), 32'h9);
    btn_raw = 4'b0000;
    edges(6);
    cmp("t4_release", 32'(release_pulse), 32'h9);
    edges(2);

    // Disable / re-enable channel 1 while held
    btn_raw[1] = 1'b1;
    edges(6);
    cmp("t5_level", 32'(btn_level), 32'h2);
    ch_en[1] = 1'b0;
    edges(1);
    cmp("t5_disabled_level", 32'(btn_level), 32'h0);
    cmp("t5_no_release", 32'(release_pulse), 32'h0);
    edges(3);
    ch_en[1] = 1'b1;
    edges(3);
    cmp("t5_no_early_press", 32'(press_pulse), 32'h0);
    edges(1);
    cmp("t5_repress", 32'(press_pulse), 32'h2);
    btn_raw[1] = 1'b0;
    edges(8);

    // Reset during long hold on channel 0
    btn_raw[0] = 1'b1;
    edges(16);
    cmp("t6_long_held", 32'(long_held), 32'h1);
    rst = 1'b1;
    edges(1);
    cmp("t6_reset_outputs", 32'({btn_level, press_pulse, release_pulse, long_pulse, long_held}), 32'h0);
    rst = 1'b0;
    edges(5);
    cmp("t6_no_release", 32'(release_pulse), 32'h0);
    cmp("t6_level_low", 32'(btn_level), 32'h0);
    edges(1);
    cmp("t6_repress", 32'(press_pulse), 32'h1);
    btn_raw[0] = 1'b0;
    edges(8);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (hold_left[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 25));
        end else begin
          hold_left[i]--;
        end
        if ($urandom_range(0, 199) == 0) ch_en[i] = ~ch_en[i];
      end
      rst = ($urandom_range(0, 599) == 0);
      edges(1);
    end

    rst     = 1'b0;
    ch_en   = '1;
    btn_raw = '0;
    edges(10);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debouncer_nch.md
DEBOUNCER_NCH -- requirements
Module: debouncer_nch

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, legal range 1..32.
REQ-002 SHALL have parameter STABLE_CNT, default 30: consecutive stable cycles required to accept a level change, legal range 2..65535.
REQ-003 SHALL have parameter LONG_CNT, default 1000: held cycles after acceptance of a press before a long-press event, legal range 1..2^20.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_raw  input  N_CH  asynchronous raw button inputs, bit i is channel i.
REQ-007 ch_en  input  N_CH  per-channel enable, synchronous.
REQ-008 btn_level  output  N_CH  debounced level per channel, registered.
REQ-009 press_pulse  output  N_CH  one-cycle pulse on an accepted 0->1 transition, registered.
REQ-010 release_pulse  output  N_CH  one-cycle pulse on an accepted 1->0 transition, registered.
REQ-011 long_pulse  output  N_CH  one-cycle pulse when a press has been held LONG_CNT cycles, registered.
REQ-012 long_held  output  N_CH  level, high from long_pulse until the accepted release, registered.

Function
REQ-013 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second-stage output (sync) SHALL feed the debounce logic.
REQ-014 Each channel SHALL have a stability counter:
- sized to hold STABLE_CNT-1;
- increments on each cycle where sync != btn_level;
- clears to 0 on any cycle where sync == btn_level.
REQ-015 When sync != btn_level and the stability counter equals STABLE_CNT-1, then at the next edge:
- btn_level SHALL toggle;
- the stability counter SHALL clear.
REQ-016 Latency: a clean raw step held steadily SHALL appear on btn_level at the (STABLE_CNT+2)-th rising edge, counting the first edge that samples the new raw value.
REQ-017 A raw pulse or glitch whose synchronized width is shorter than STABLE_CNT cycles SHALL produce no change on any output.
REQ-018 press_pulse[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 1; release_pulse[i] likewise for the first cycle btn_level[i] reads 0.
REQ-019 Each channel SHALL implement a state machine with states RELEASED, PRESSED and LONG; the transitions SHALL be:
- RELEASED->PRESSED on accepted rise;
- PRESSED->LONG when the hold counter reaches LONG_CNT;
- PRESSED->RELEASED and LONG->RELEASED on accepted fall.
REQ-020 The hold counter SHALL clear on accepted rise and increment each cycle in PRESSED.
REQ-021 long_pulse[i] SHALL assert for one cycle exactly LONG_CNT cycles after the cycle in which press_pulse[i] is high, coincident with entry to LONG.
REQ-022 In LONG, the hold counter SHALL stop, and no further long_pulse SHALL occur until the next accepted press.
REQ-023 An accepted fall in the same cycle the hold counter would reach LONG_CNT SHALL take priority:
- release_pulse asserts;
- long_pulse and long_held do not assert.
REQ-024 While ch_en[i]=0:
- btn_level[i], long_held[i], all pulses and all channel i counters SHALL be 0, and the state SHALL be RELEASED;
- disabling a pressed channel SHALL NOT emit release_pulse.
REQ-025 Re-enabling a channel SHALL restart debounce from btn_level=0, so a button already held produces press_pulse STABLE_CNT cycles later.
REQ-026 Channels SHALL be fully independent; simultaneous events on any subset of channels SHALL each be reported in the same cycle.
REQ-027 No output SHALL depend combinationally on any input.

Reset
REQ-028 While rst=1 at a rising edge, all synchronizer flops, counters, states and outputs SHALL go to 0 / RELEASED at that edge.
REQ-029 Reset asserted mid-press or mid-long-hold SHALL emit no release_pulse, either during or after reset.
REQ-030 In the first cycle after rst deasserts, all outputs SHALL be 0, and a held button SHALL follow REQ-016 latency from the first post-reset sampling edge.

Verification (N_CH=4, STABLE_CNT=4, LONG_CNT=10)
REQ-031 btn_raw[0] 0->1, held: btn_level[0]=1 and press_pulse[0]=1 at edge 6; press_pulse[0]=0 at edge 7; other channels stay 0.
REQ-032 btn_raw[1] bounce 1,0,1,1,0 (one cycle each), then steady 1: no output activity during the bounce; press_pulse[1] 6 edges after the steady 1 begins.
REQ-033 Channel 2 held: long_pulse[2] exactly 10 cycles after press_pulse[2], long_held[2]=1 until the accepted release; on release, release_pulse[2]=1 and long_held[2]=0 in the same cycle; long_pulse fires once only.
REQ-034 Channels 0 and 3 pressed on the same edge: press_pulse=4'b1001 in a single cycle; both released together give release_pulse=4'b1001.
REQ-035 Channel 1 pressed, then ch_en[1]=0: btn_level[1]=0 next cycle with no release_pulse; ch_en[1]=1 with the button still held gives press_pulse[1] 4 cycles later.
REQ-036 rst pulsed for 1 cycle while channel 0 is in LONG: all outputs 0 and no release_pulse; the held button re-presses at edge 6 after reset deasserts.
